// File: rtl/mux_pkg.sv
// Shared encodings for the muxed serial link: FSM states and lane select values.
package mux_pkg;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      RUN_A     = 2'd1,
      RUN_B     = 2'd2
   } state_t;

   localparam logic LANE_A = 1'b0;
   localparam logic LANE_B = 1'b1;

endpackage

// File: rtl/demux_lane.sv
// One receive lane: MSB-first shift register, bit counter, word register,
// valid/drop pulses and a wrapping completed-word counter.
module demux_lane #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             accept,
   input  logic             din,
   input  logic             flush,
   output logic [WIDTH-1:0] word,
   output logic             valid,
   output logic             drop,
   output logic [CNT_W-1:0] count
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

   logic [WIDTH-1:0] shift;
   logic [BW-1:0]    bcnt;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         shift <= '0;
         bcnt  <= '0;
         word  <= '0;
         valid <= 1'b0;
         drop  <= 1'b0;
         count <= '0;
      end else begin
         valid <= 1'b0;
         drop  <= 1'b0;
         // flush and accept never target the same lane on one edge; flush wins anyway
         if (flush) begin
            drop  <= (bcnt != '0);
            bcnt  <= '0;
            shift <= '0;
         end else if (accept) begin
            shift <= {shift[WIDTH-2:0], din};
            if (bcnt == LAST) begin
               word  <= {shift[WIDTH-2:0], din};
               valid <= 1'b1;
               count <= count + CNT_W'(1);
               bcnt  <= '0;
            end else begin
               bcnt <= bcnt + BW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/demuxtwo_deser.sv
// Receive side of the two-input serial mux: recovers lane A/B bit streams
// from the muxed line using the lane select, and deserializes each lane.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// WAIT_SYNC | no lane alignment yet; din ignored until the first sl edge
// RUN_A     | sl low, bits go to lane A
// RUN_B     | sl high, bits go to lane B
module demuxtwo_deser
   import mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             din,
   input  logic             din_en,
   input  logic             sl,
   output logic [WIDTH-1:0] a_word,
   output logic             a_valid,
   output logic             a_drop,
   output logic [CNT_W-1:0] a_count,
   output logic [WIDTH-1:0] b_word,
   output logic             b_valid,
   output logic             b_drop,
   output logic [CNT_W-1:0] b_count,
   output logic             synced
);

   state_t state_q, state_d;
   logic   sl_q;
   logic   sl_edge;
   logic   accept_a, accept_b, flush_a, flush_b;

   assign sl_edge = (sl != sl_q);
   assign synced  = (state_q != WAIT_SYNC);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_SYNC;
         sl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sl_q    <= sl;
      end
   end

   // Steering uses the current sl, so the bit on a switch edge lands in the new lane.
   always_comb begin
      state_d  = state_q;
      accept_a = 1'b0;
      accept_b = 1'b0;
      flush_a  = 1'b0;
      flush_b  = 1'b0;
      case (state_q)
         WAIT_SYNC: begin
            if (sl_edge) begin
               state_d  = (sl == LANE_A) ? RUN_A : RUN_B;
               accept_a = din_en && (sl == LANE_A);
               accept_b = din_en && (sl == LANE_B);
            end
         end
         RUN_A: begin
            if (sl_edge) begin
               state_d = RUN_B;
               flush_a = 1'b1;
            end
            accept_a = din_en && (sl == LANE_A);
            accept_b = din_en && (sl == LANE_B);
         end
         RUN_B: begin
            if (sl_edge) begin
               state_d = RUN_A;
               flush_b = 1'b1;
            end
            accept_a = din_en && (sl == LANE_A);
            accept_b = din_en && (sl == LANE_B);
         end
         default: state_d = WAIT_SYNC;
      endcase
   end

   demux_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane_a (
      .clock  (clock),
      .rst_n  (rst_n),
      .accept (accept_a),
      .din    (din),
      .flush  (flush_a),
      .word   (a_word),
      .valid  (a_valid),
      .drop   (a_drop),
      .count  (a_count)
   );

   demux_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane_b (
      .clock  (clock),
      .rst_n  (rst_n),
      .accept (accept_b),
      .din    (din),
      .flush  (flush_b),
      .word   (b_word),
      .valid  (b_valid),
      .drop   (b_drop),
      .count  (b_count)
   );

endmodule

// File: tb/tb_demuxtwo_deser.sv
// Directed bench for demuxtwo_deser: a reference model predicts per-edge
// pulses/counts and queues expected words, popped when the DUT raises valid.
module tb_demuxtwo_deser;
   import mux_pkg::*;

   localparam int WIDTH = 8;
   localparam int CNT_W = 8;

   logic             clock = 1'b0;
   logic             rst_n = 1'b0;
   logic             din = 1'b0;
   logic             din_en = 1'b0;
   logic             sl = 1'b0;
   logic [WIDTH-1:0] a_word, b_word;
   logic             a_valid, b_valid, a_drop, b_drop, synced;
   logic [CNT_W-1:0] a_count, b_count;

   demuxtwo_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock   (clock),
      .rst_n   (rst_n),
      .din     (din),
      .din_en  (din_en),
      .sl      (sl),
      .a_word  (a_word),
      .a_valid (a_valid),
      .a_drop  (a_drop),
      .a_count (a_count),
      .b_word  (b_word),
      .b_valid (b_valid),
      .b_drop  (b_drop),
      .b_count (b_count),
      .synced  (synced)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] q_a[$];
   logic [WIDTH-1:0] q_b[$];
   logic [WIDTH-1:0] m_shift[2];
   int               m_cnt[2];
   logic [CNT_W-1:0] m_count[2];
   logic [WIDTH-1:0] m_word[2];
   logic             m_sync;
   logic             m_slq;
   int               n_a_valid;
   int               n_b_valid;
   int               n_drop_obs;
   int               n_drop_exp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int l = 0; l < 2; l++) begin
         m_shift[l] = '0;
         m_cnt[l]   = 0;
         m_count[l] = '0;
         m_word[l]  = '0;
      end
      m_sync = 1'b0;
      m_slq  = 1'b0;
      q_a.delete();
      q_b.delete();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_a_word"}, a_word, 0);
      chk({tag, "_a_valid"}, a_valid, 0);
      chk({tag, "_a_drop"}, a_drop, 0);
      chk({tag, "_a_count"}, a_count, 0);
      chk({tag, "_b_word"}, b_word, 0);
      chk({tag, "_b_valid"}, b_valid, 0);
      chk({tag, "_b_drop"}, b_drop, 0);
      chk({tag, "_b_count"}, b_count, 0);
      chk({tag, "_synced"}, synced, 0);
   endtask

   // One clock edge: drive inputs, predict, then compare after the edge.
   task automatic step(input logic d, input logic en, input logic s);
      logic       e_v[2];
      logic       e_d[2];
      logic       sl_edge;
      int         l;
      int         leave;
      logic [1:0] e_state;
      logic [WIDTH-1:0] w;
      @(negedge clock);
      din = d; din_en = en; sl = s;
      e_v[0] = 1'b0; e_v[1] = 1'b0; e_d[0] = 1'b0; e_d[1] = 1'b0;
      sl_edge = (s != m_slq);
      if (m_sync && sl_edge) begin
         leave = (s == LANE_A) ? 1 : 0;
         if (m_cnt[leave] != 0) begin
            e_d[leave] = 1'b1;
            n_drop_exp++;
         end
         m_cnt[leave]   = 0;
         m_shift[leave] = '0;
      end
      if ((m_sync || sl_edge) && en) begin
         l = (s == LANE_A) ? 0 : 1;
         m_shift[l] = {m_shift[l][WIDTH-2:0], d};
         m_cnt[l]++;
         if (m_cnt[l] == WIDTH) begin
            m_cnt[l]   = 0;
            e_v[l]     = 1'b1;
            m_count[l] = m_count[l] + CNT_W'(1);
            m_word[l]  = m_shift[l];
            if (l == 0) q_a.push_back(m_shift[l]);
            else q_b.push_back(m_shift[l]);
         end
      end
      if (sl_edge) m_sync = 1'b1;
      m_slq = s;
      e_state = !m_sync ? WAIT_SYNC : (m_slq ? RUN_B : RUN_A);

      @(posedge clock);
      #1;
      chk("a_valid", a_valid, e_v[0]);
      chk("b_valid", b_valid, e_v[1]);
      chk("a_drop", a_drop, e_d[0]);
      chk("b_drop", b_drop, e_d[1]);
      chk("a_count", a_count, m_count[0]);
      chk("b_count", b_count, m_count[1]);
      chk("a_word_hold", a_word, m_word[0]);
      chk("b_word_hold", b_word, m_word[1]);
      chk("synced", synced, m_sync);
      chk("state", dut.state_q, e_state);
      if (a_drop === 1'b1 || b_drop === 1'b1) n_drop_obs++;
      if (a_valid === 1'b1) begin
         n_a_valid++;
         chk("a_sb_nonempty", q_a.size() > 0, 1);
         if (q_a.size() > 0) begin
            w = q_a.pop_front();
            chk("a_word_sb", a_word, w);
         end
      end
      if (b_valid === 1'b1) begin
         n_b_valid++;
         chk("b_sb_nonempty", q_b.size() > 0, 1);
         if (q_b.size() > 0) begin
            w = q_b.pop_front();
            chk("b_word_sb", b_word, w);
         end
      end
   endtask

   initial begin
      logic [7:0] pat;
      int a_cnt_before;
      model_reset();
      n_a_valid = 0; n_b_valid = 0; n_drop_obs = 0; n_drop_exp = 0;

      repeat (2) @(negedge clock);
      check_all_zero("reset");
      rst_n = 1'b1;

      // sl held low: nothing is accepted before the first sl edge
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, LANE_A);
      chk("presync_a_valids", n_a_valid, 0);

      // sync via 0->1, then 1->0 into lane A and shift in 8'hB2
      step(1'b0, 1'b0, LANE_B);
      step(1'b0, 1'b0, LANE_A);
      pat = 8'hB2;
      for (int i = 7; i >= 0; i--) step(pat[i], 1'b1, LANE_A);
      chk("a_word_b2", a_word, 8'hB2);
      chk("a_count_1", a_count, 1);

      // 3 bits on A, switch with a bit on the switch edge, then 7 more on B -> 8'hAA
      step(1'b1, 1'b1, LANE_A);
      step(1'b1, 1'b1, LANE_A);
      step(1'b1, 1'b1, LANE_A);
      a_cnt_before = n_a_valid;
      step(1'b1, 1'b1, LANE_B);
      chk("switch_a_drop", a_drop, 1);
      pat = 8'hAA;
      for (int i = 6; i >= 0; i--) step(pat[i], 1'b1, LANE_B);
      chk("b_word_aa", b_word, 8'hAA);
      chk("b_count_1", b_count, 1);
      chk("a_count_unchanged", a_count, 1);
      chk("no_a_valid_during_b", n_a_valid, a_cnt_before);

      // lane B at 5 bits, then asynchronous reset mid-cycle
      for (int i = 0; i < 5; i++) step(1'(i), 1'b1, LANE_B);
      @(posedge clock);
      #3 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      model_reset();
      @(negedge clock);
      sl = LANE_A; din = 1'b1; din_en = 1'b1;
      @(negedge clock);
      rst_n = 1'b1;
      a_cnt_before = n_a_valid;
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, LANE_A);
      chk("post_rst_ignored", n_a_valid, a_cnt_before);

      // resync into lane A and run 256 back-to-back words
      step(1'b0, 1'b0, LANE_B);
      step(1'b0, 1'b0, LANE_A);
      a_cnt_before = n_a_valid;
      for (int i = 0; i < 256 * WIDTH; i++) step(1'($urandom_range(1)), 1'b1, LANE_A);
      chk("wrap_valid_pulses", n_a_valid - a_cnt_before, 256);
      chk("wrap_a_count", a_count, 0);

      // sl toggled every cycle: only drops, never valids
      a_cnt_before = n_a_valid + n_b_valid;
      for (int i = 0; i < 24; i++) step(1'($urandom_range(1)), 1'b1, (i % 2 == 0) ? LANE_B : LANE_A);
      chk("toggle_no_valid", n_a_valid + n_b_valid, a_cnt_before);
      chk("drop_total", n_drop_obs, n_drop_exp);
      chk("a_sb_empty", q_a.size(), 0);
      chk("b_sb_empty", q_b.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/demuxtwo_deser.md
Name: demuxtwo_deser

Overview:
- Receive-side counterpart of the two-input serial mux (muxtwo).
- Takes the single muxed bit line plus its lane select and splits it back into lane A and lane B.
- Deserializes each lane into WIDTH-bit words, MSB first, and pulses a per-lane valid.
- Sits at the far end of the muxed link, clocked by the same clock as the transmitter's sampling logic.

Parameters:
- WIDTH, 8, bits per deserialized word; legal range 2..32.
- CNT_W, 8, width of the per-lane word counters; counters wrap at 2^CNT_W.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous; release is synchronous to clock.
- din  input  1  muxed serial bit, already muxed by the transmitter.
- din_en  input  1  sample strobe; din is accepted only on edges where din_en=1.
- sl  input  1  lane select, same polarity as muxtwo: 0 = lane A, 1 = lane B.
- a_word  output  WIDTH  last completed lane-A word.
- a_valid  output  1  one-cycle pulse: a_word updated.
- a_drop  output  1  one-cycle pulse: a partial lane-A word was discarded.
- a_count  output  CNT_W  number of completed lane-A words, wrapping.
- b_word, b_valid, b_drop, b_count: same four outputs for lane B.
- synced  output  1  high once the first sl transition after reset has been seen.

Behaviour:
- Reset values: all outputs 0, FSM in WAIT_SYNC, shift registers and bit counters 0, sl_q = 0.
- sl_q is sl registered every cycle. "sl edge" means sl != sl_q at a rising clock edge.
- FSM has three states:
  - WAIT_SYNC: all din discarded and no pulses. On an sl edge go to RUN_A if sl=0, RUN_B if sl=1; synced <= 1. The bit sampled on this same edge is accepted into the new lane.
  - RUN_A: on an sl edge go to RUN_B. Otherwise stay.
  - RUN_B: on an sl edge go to RUN_A. Otherwise stay.
- Lane steering: the bit is routed by the current sl, not sl_q. This holds in RUN states and on the WAIT_SYNC exit edge.
- Accept (active lane, din_en=1):
  - shift <= {shift[WIDTH-2:0], din}; bcnt <= bcnt+1.
  - When bcnt == WIDTH-1 on an accept edge: word <= {shift[WIDTH-2:0], din}; valid <= 1 for exactly one cycle; count <= count+1 (wraps from 2^CNT_W-1 to 0); bcnt <= 0.
  - Latency: the word and pulse are visible in the cycle after the edge that accepted bit WIDTH.
- Lane switch (sl edge while in RUN_A or RUN_B):
  - If the lane being left has bcnt != 0, pulse its drop for one cycle and clear its bcnt and shift.
  - If the left lane's bcnt == 0, no drop pulse.
  - The entering lane always starts at bcnt=0.
- Simultaneous events:
  - Completion and switch on the same edge cannot collide: the completing bit belongs to the new lane.
  - A switch edge with din_en=0 still performs the drop and clear.
- The inactive lane holds its word and count. Its valid and drop stay 0 except for the switch-edge drop pulse above.
- word outputs hold their value until the next completion.
- din_en=0 in a RUN state: no state change except sl-edge handling.
- Reset mid-word: everything returns to reset values immediately. synced falls, and the block re-enters WAIT_SYNC.
- sl toggling on every cycle: each edge is handled independently. Drops occur as per the rules; no lockup.

Decomposition:
- Shared package mux_pkg holds:
  - FSM state encodings (WAIT_SYNC=2'd0, RUN_A=2'd1, RUN_B=2'd2).
  - Lane select constants LANE_A=1'b0, LANE_B=1'b1.
- Sub-module demux_lane, instantiated twice, contains the shift register, bit counter, word register, valid/drop pulse generation and word counter.
  - demux_lane inputs: clock, rst_n, accept, bit, flush.
  - demux_lane outputs: word, valid, drop, count.
- The top module holds sl_q, the FSM, and the accept/flush steering.

Test Plan:
- Reset then din_en=1, din=1 for 20 cycles with sl held at 0 -> no valid, synced=0, both counts 0.
- sl 1->0 edge, then 8 accepted bits 1,0,1,1,0,0,1,0 on lane A (WIDTH=8) -> a_word=8'hB2, a_valid high exactly one cycle after the 8th accept, a_count=1, no B outputs.
- Lane A at 3 bits, sl 0->1 with din_en=1 on that edge -> a_drop pulse once, that bit is bit 1 of lane B; 7 more bits, then b_valid with b_count=1, a_count unchanged.
- 256 back-to-back lane-A words with CNT_W=8 -> a_count wraps to 0 on the 256th word, and exactly 256 a_valid pulses.
- rst_n pulled low asynchronously (mid-cycle) with lane B at 5 bits -> all outputs 0 immediately; after release, bits are ignored until the next sl edge.
- sl toggled every cycle with din_en=1 and WIDTH=2 -> every partial word produces a drop pulse, no valid pulses, and the FSM alternates RUN_A/RUN_B.
